// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the decode-stage hazard controller: FSM states,
// register index width and the opcode constants the decode stage steers on.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    HS_RUN    = 2'b00,
    HS_LSTALL = 2'b01,
    HS_FLUSH  = 2'b10
  } hs_e;

  localparam logic [4:0] OP_LOAD  = 5'b01010;
  localparam logic [4:0] OP_STORE = 5'b01011;
  localparam logic [4:0] OP_BR    = 5'b01111;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JAL   = 5'b10001;
  localparam logic [4:0] OP_JR    = 5'b10010;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic stall_flush;
    logic pipe_hold;
  } haz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by the instruction in ID. r0 is hardwired zero and never creates a hazard.
module haz_lu_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_reg_read,
  input  logic              id_rs2_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  always_comb begin
    load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
               ((id_reg_read  && (ex_rd == id_rs1)) ||
                (id_rs2_valid && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use stalls, EX redirect flushes and
// mem_busy freeze. Define HAZ_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW          = 5,
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned CNT_W           = 3
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned PERF_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_reg_read,
  input  logic              id_rs2_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              stall_flush,
  output logic              pipe_hold,
  output logic [1:0]        hazard_state
`ifdef HAZ_PERF_CNT_EN
  , output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0]   perf_flush_cnt
`endif
);

  import hazard_ctrl_pkg::*;

  hs_e              state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  haz_ctrl_t        ctl;
  logic             load_use;

  haz_lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_reg_read  (id_reg_read),
    .id_rs2_valid (id_rs2_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .load_use     (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HS_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctl       = '0;
    if (mem_busy) begin
      ctl.pipe_hold = 1'b1;
    end else if (ex_redirect) begin
      ctl.pc_write    = 1'b1;
      ctl.ifid_flush  = 1'b1;
      ctl.idex_flush  = 1'b1;
      ctl.stall_flush = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = HS_FLUSH;
        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt = HS_RUN;
        cnt_nxt   = '0;
      end
    end else if (state == HS_FLUSH) begin
      ctl.pc_write    = 1'b1;
      ctl.ifid_flush  = 1'b1;
      ctl.stall_flush = 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_nxt = HS_RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end else if (state == HS_LSTALL) begin
      ctl.stall_flush = 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_nxt = HS_RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end else if (load_use) begin
      ctl.stall_flush = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_nxt = HS_LSTALL;
        cnt_nxt   = CNT_W'(LU_STALL_CYCLES - 1);
      end
    end else begin
      ctl.pc_write   = 1'b1;
      ctl.ifid_write = 1'b1;
    end
  end

  // While reset is asserted the pipe is forced into a flushed, non-advancing state.
  always_comb begin
    pc_write     = rst_n && ctl.pc_write;
    ifid_write   = rst_n && ctl.ifid_write;
    ifid_flush   = !rst_n || ctl.ifid_flush;
    idex_flush   = !rst_n || ctl.idex_flush;
    stall_flush  = !rst_n || ctl.stall_flush;
    pipe_hold    = rst_n && ctl.pipe_hold;
    hazard_state = state;
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_cyc, flush_cyc;

  always_comb begin
    flush_cyc = !mem_busy && (ex_redirect || (state == HS_FLUSH));
    stall_cyc = !mem_busy && !ex_redirect &&
                ((state == HS_LSTALL) || ((state == HS_RUN) && load_use));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_cyc && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
      if (flush_cyc && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: one default-parameter instance driven by a
// vector table, one LU_STALL_CYCLES=3 / FLUSH_CYCLES=3 instance for multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_reg_read, id_rs2_valid, ex_mem_read, ex_reg_write, ex_redirect, mem_busy;

  logic       d_pcw, d_ifw, d_iff, d_idf, d_sf, d_ph;
  logic [1:0] d_hs;
  logic       c_pcw, c_ifw, c_iff, c_idf, c_sf, c_ph;
  logic [1:0] c_hs;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] d_pst, d_pfl, c_pst, c_pfl;
`endif

  logic [5:0] d_vec, c_vec;
  assign d_vec = {d_pcw, d_ifw, d_iff, d_idf, d_sf, d_ph};
  assign c_vec = {c_pcw, c_ifw, c_iff, c_idf, c_sf, c_ph};

  // {pc_write, ifid_write, ifid_flush, idex_flush, stall_flush, pipe_hold}
  localparam logic [5:0] V_RUN   = 6'b110000;
  localparam logic [5:0] V_STALL = 6'b000010;
  localparam logic [5:0] V_REDIR = 6'b101110;
  localparam logic [5:0] V_FLUSH = 6'b101010;
  localparam logic [5:0] V_BUSY  = 6'b000001;
  localparam logic [5:0] V_RST   = 6'b001110;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(3)) u_dut_def (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_reg_read(id_reg_read), .id_rs2_valid(id_rs2_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(d_pcw), .ifid_write(d_ifw), .ifid_flush(d_iff), .idex_flush(d_idf),
    .stall_flush(d_sf), .pipe_hold(d_ph), .hazard_state(d_hs)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt(d_pst), .perf_flush_cnt(d_pfl)
`endif
  );

  hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(3)) u_dut_cfg (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_reg_read(id_reg_read), .id_rs2_valid(id_rs2_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(c_pcw), .ifid_write(c_ifw), .ifid_flush(c_iff), .idex_flush(c_idf),
    .stall_flush(c_sf), .pipe_hold(c_ph), .hazard_state(c_hs)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt(c_pst), .perf_flush_cnt(c_pfl)
`endif
  );

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       rr, r2v, mr, rw, redir, busy;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[12];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_reg_read = 1'b0; id_rs2_valid = 1'b0; ex_mem_read = 1'b0;
    ex_reg_write = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic load_use_r5();
    idle();
    id_rs1 = 5'd5; id_reg_read = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          name        rs1    rs2    rd     rr  r2v mr  rw  red bsy exp
    vt[0]  = '{"lu_rs1_r5",  5'd5,  5'd0,  5'd5,  1, 0, 1, 1, 0, 0, V_STALL};
    vt[1]  = '{"lu_r0",      5'd0,  5'd0,  5'd0,  1, 1, 1, 1, 0, 0, V_RUN};
    vt[2]  = '{"lu_rs2",     5'd1,  5'd7,  5'd7,  1, 1, 1, 1, 0, 0, V_STALL};
    vt[3]  = '{"rs2_noval",  5'd1,  5'd7,  5'd7,  1, 0, 1, 1, 0, 0, V_RUN};
    vt[4]  = '{"rs1_noread", 5'd9,  5'd0,  5'd9,  0, 0, 1, 1, 0, 0, V_RUN};
    vt[5]  = '{"not_load",   5'd9,  5'd0,  5'd9,  1, 0, 0, 1, 0, 0, V_RUN};
    vt[6]  = '{"no_regwr",   5'd9,  5'd0,  5'd9,  1, 0, 1, 0, 0, 0, V_RUN};
    vt[7]  = '{"redir_lu",   5'd9,  5'd0,  5'd9,  1, 0, 1, 1, 1, 0, V_REDIR};
    vt[8]  = '{"busy_redir", 5'd9,  5'd0,  5'd9,  1, 0, 1, 1, 1, 1, V_BUSY};
    vt[9]  = '{"plain_run",  5'd3,  5'd4,  5'd6,  1, 1, 1, 1, 0, 0, V_RUN};
    vt[10] = '{"lu_r31",     5'd31, 5'd0,  5'd31, 1, 0, 1, 1, 0, 0, V_STALL};
    vt[11] = '{"rd_1bit",    5'd30, 5'd30, 5'd31, 1, 1, 1, 1, 0, 0, V_RUN};

    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_def_out", d_vec, V_RST);
    chk("rst_def_hs",  d_hs, 2'b00);
    chk("rst_cfg_out", c_vec, V_RST);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      tick();
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; ex_rd = vt[i].rd;
      id_reg_read = vt[i].rr; id_rs2_valid = vt[i].r2v;
      ex_mem_read = vt[i].mr; ex_reg_write = vt[i].rw;
      ex_redirect = vt[i].redir; mem_busy = vt[i].busy;
      #2;
      chk(vt[i].name, d_vec, vt[i].exp);
      chk({vt[i].name, "_hs"}, d_hs, 2'b00);
    end

    // let the cfg instance drain back to RUN
    for (int i = 0; i < 6; i++) begin tick(); idle(); end

    // multi-cycle flush
    tick(); idle(); ex_redirect = 1'b1; #2;
    chk("t3_c0", c_vec, V_REDIR); chk("t3_c0_hs", c_hs, 2'b00);
    tick(); idle(); #2;
    chk("t3_c1", c_vec, V_FLUSH); chk("t3_c1_hs", c_hs, 2'b10);
    tick(); #2;
    chk("t3_c2", c_vec, V_FLUSH); chk("t3_c2_hs", c_hs, 2'b10);
    tick(); #2;
    chk("t3_c3", c_vec, V_RUN); chk("t3_c3_hs", c_hs, 2'b00);

    // redirect cancels a load-use stall
    tick(); load_use_r5(); #2;
    chk("t4_c0", c_vec, V_STALL); chk("t4_c0_hs", c_hs, 2'b00);
    tick(); idle(); ex_redirect = 1'b1; #2;
    chk("t4_c1", c_vec, V_REDIR); chk("t4_c1_hs", c_hs, 2'b01);
    tick(); idle(); #2;
    chk("t4_c2", c_vec, V_FLUSH); chk("t4_c2_hs", c_hs, 2'b10);
    tick(); tick(); #2;
    chk("t4_c4_hs", c_hs, 2'b00);

    // mem_busy freezes an LSTALL with cnt=2
    tick(); load_use_r5(); #2;
    chk("t5_lu", c_vec, V_STALL);
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); mem_busy = 1'b1; #2;
      chk("t5_busy", c_vec, V_BUSY); chk("t5_busy_hs", c_hs, 2'b01);
    end
    tick(); idle(); #2;
    chk("t5_s1", c_vec, V_STALL); chk("t5_s1_hs", c_hs, 2'b01);
    tick(); #2;
    chk("t5_s2", c_vec, V_STALL); chk("t5_s2_hs", c_hs, 2'b01);
    tick(); #2;
    chk("t5_run", c_vec, V_RUN); chk("t5_run_hs", c_hs, 2'b00);

    // async reset in the middle of a flush
    tick(); idle(); ex_redirect = 1'b1;
    tick(); idle(); #2;
    chk("t6_pre_hs", c_hs, 2'b10);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", c_vec, V_RST); chk("t6_rst_hs", c_hs, 2'b00);
    #1 rst_n = 1'b1;
    tick(); #2;
    chk("t6_post", c_vec, V_RUN); chk("t6_post_hs", c_hs, 2'b00);
`ifdef HAZ_PERF_CNT_EN
    chk("t6_perf_st", c_pst, 32'd0);
    chk("t6_perf_fl", c_pfl, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
